// File: rtl/postproc_arbiter.sv
// Arbitrates FMA and divsqrt results into a shared LAT-deep postprocessing pipeline.
// Define POSTARB_FIXED_PRIO_EN to make the FMA always win contention; the default is round-robin.
module postproc_arbiter #(
  parameter int LAT  = 2,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            FmaReq,
  input  logic            DivReq,
  input  logic [2:0]      FmaFrm,
  input  logic [2:0]      DivFrm,
  input  logic [TAGW-1:0] FmaTag,
  input  logic [TAGW-1:0] DivTag,
  input  logic            FlushE,
  input  logic            RespReady,
  output logic            FmaGnt,
  output logic            DivGnt,
  output logic            PostSel,
  output logic            PostEn,
  output logic [2:0]      PostFrm,
  output logic            RespValid,
  output logic [TAGW-1:0] RespTag,
  output logic            RespSrc
);

  logic [LAT-1:0]           valid_q, valid_d;
  logic [LAT-1:0]           src_q, src_d;
  logic [LAT-1:0][TAGW-1:0] tag_q, tag_d;

  logic advance;
  logic can_grant;
  logic sel_div;

  // The whole pipeline moves as one unit: it advances unless the finished result is blocked.
  assign advance   = ~valid_q[LAT-1] | RespReady;
  assign can_grant = resetn & advance & ~FlushE;

`ifdef POSTARB_FIXED_PRIO_EN
  assign sel_div = DivReq & ~FmaReq;
`else
  logic last_src_q, last_src_d;

  // On contention the source opposite the most recent grant wins.
  assign sel_div    = DivReq & (~FmaReq | ~last_src_q);
  assign last_src_d = (FmaGnt | DivGnt) ? DivGnt : last_src_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) last_src_q <= 1'b1;
    else         last_src_q <= last_src_d;
  end
`endif

  assign DivGnt  = can_grant & sel_div;
  assign FmaGnt  = can_grant & FmaReq & ~sel_div;
  assign PostEn  = FmaGnt | DivGnt;
  assign PostSel = DivGnt;
  assign PostFrm = DivGnt ? DivFrm : (FmaGnt ? FmaFrm : 3'b000);

  always_comb begin
    valid_d = valid_q;
    src_d   = src_q;
    tag_d   = tag_q;
    if (advance) begin
      for (int i = 1; i < LAT; i++) begin
        valid_d[i] = valid_q[i-1];
        src_d[i]   = src_q[i-1];
        tag_d[i]   = tag_q[i-1];
      end
      valid_d[0] = PostEn;
      src_d[0]   = DivGnt;
      tag_d[0]   = DivGnt ? DivTag : FmaTag;
    end
    // Flush wins over a stall, so a held result is dropped too.
    if (FlushE) valid_d = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      src_q   <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      src_q   <= src_d;
      tag_q   <= tag_d;
    end
  end

  assign RespValid = valid_q[LAT-1];
  assign RespSrc   = src_q[LAT-1];
  assign RespTag   = tag_q[LAT-1];

endmodule

// File: doc/postproc_arbiter.md
POSTPROC_ARBITER -- requirements
Module: postproc_arbiter

Interface
REQ-001 Parameter LAT, default 2, meaning postprocessing pipeline depth in cycles (legal 1..4).
REQ-002 Parameter TAGW, default 5, meaning destination-register tag width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 FmaReq  input  1  FMA unit holds a result ready for postprocessing.
REQ-006 DivReq  input  1  divsqrt unit holds a result ready for postprocessing.
REQ-007 FmaFrm, DivFrm  input  3 each  rounding mode of each requester's operation.
REQ-008 FmaTag, DivTag  input  TAGW each  destination tag of each requester's operation.
REQ-009 FlushE  input  1  kill all pending and in-flight operations.
REQ-010 RespReady  input  1  writeback accepts the response this cycle.
REQ-011 FmaGnt, DivGnt  output  1 each  grant; the requester's operation is consumed this cycle.
REQ-012 PostSel  output  1  datapath input mux select, 0=FMA, 1=divsqrt; valid with PostEn.
REQ-013 PostEn  output  1  postprocessing stage 0 captures an operation.
REQ-014 PostFrm  output  3  rounding mode forwarded with the granted operation.
REQ-015 RespValid  output  1  the last pipeline stage holds a finished result.
REQ-016 RespTag  output  TAGW  tag of the finished result.
REQ-017 RespSrc  output  1  source of the finished result, 0=FMA, 1=divsqrt.

Function
REQ-018 Internal pipeline: LAT stages, each holding valid, src and tag; stage LAT-1 drives RespValid, RespSrc and RespTag.
REQ-019 Advance = ~RespValid | RespReady; when Advance=1, all stages shift by one in the same cycle; when Advance=0, all stages hold.
REQ-020 Grant is issued only when Advance=1 and FlushE=0; at most one grant per cycle.
REQ-021 Grant is combinational from the requests and the arbitration state; FmaGnt/DivGnt is never asserted without the matching request.
REQ-022 Grant loads stage 0 with valid=1, src=PostSel and the selected tag; PostEn=FmaGnt|DivGnt and PostFrm=the selected Frm in the same cycle.
REQ-023 Advance=1 with no grant loads stage 0 with a bubble (valid=0).
REQ-024 Latency: a grant in cycle N produces RespValid in cycle N+LAT when no stall occurs; each stall cycle adds one cycle.
REQ-025 Round-robin: a 1-bit LastSrc register records the source of the most recent grant; when both requests are asserted, the source opposite LastSrc wins.
REQ-026 A single active request wins regardless of LastSrc.
REQ-027 Throughput: one grant per cycle is sustained while RespReady=1.
REQ-028 FlushE=1 clears every stage valid at the next edge, suppresses grants in that cycle and leaves LastSrc unchanged.
REQ-029 FlushE has priority over stall; a held RespValid is dropped by the flush.
REQ-030 RespTag and RespSrc are don't-care while RespValid=0, but the flops are still reset.

Reset
REQ-031 resetn=0 asynchronously clears every stage valid, src and tag to 0 and sets LastSrc=1, so the FMA wins the first contention.
REQ-032 All outputs are 0 during reset; combinational grants are forced low while resetn=0.
REQ-033 Reset asserted mid-operation discards in-flight results with no response generated.

Configuration
REQ-034 With POSTARB_FIXED_PRIO_EN defined, the FMA always wins contention and LastSrc is not implemented.
REQ-035 Without POSTARB_FIXED_PRIO_EN, the round-robin arbitration of REQ-025 applies.

Verification
REQ-036 LAT=2, FmaReq=1 with tag 3 in cycle 0, RespReady=1 -> FmaGnt=1 in cycle 0; RespValid=1, RespTag=3, RespSrc=0 in cycle 2.
REQ-037 Both requests held for 4 cycles after reset (round-robin build) -> grant sequence FMA, Div, FMA, Div; in the fixed-priority build -> FMA in all 4 cycles.
REQ-038 RespValid=1 with RespReady=0 for 3 cycles and both requests held -> no grants and all stages hold; RespReady=1 -> resume one grant per cycle with no lost or duplicated tags.
REQ-039 Two operations in flight and FlushE pulsed for 1 cycle -> no grant that cycle, RespValid=0 for the next LAT cycles, then normal operation.
REQ-040 resetn deasserted for 1 cycle while the pipeline is full -> all outputs 0 immediately, no stale RespValid after release.
